// File: rtl/block_data_memory_pkg.sv
// block_data_memory_pkg: shared state encoding and widths for the block data memory.
package block_data_memory_pkg;
  localparam int MEM_ADDR_W = 6;
  localparam int MEM_DATA_W = 32;
  localparam int DEFAULT_LATENCY = 20;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;
  function automatic logic is_request(input logic rd, input logic wr);
    return rd | wr;
  endfunction
endpackage

// File: rtl/block_data_memory_latency_counter.sv
// mem_latency_counter: loadable down-counter with a zero flag that sets service latency.
module mem_latency_counter
  import block_data_memory_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             decrement,
  output logic [CNT_W-1:0] count,
  output logic             zero
);
  assign zero = count == '0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count <= '0;
    else if (load) count <= load_value;
    else if (decrement && !zero) count <= count - 1'b1;
  end
endmodule

// File: rtl/block_data_memory.sv
// block_data_memory: fixed-latency block store serving one cache-controller request at a time.
module block_data_memory
  import block_data_memory_pkg::*;
#(
  parameter int LATENCY = DEFAULT_LATENCY,
  parameter int DEPTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [MEM_ADDR_W-1:0] mem_address,
  input  logic [MEM_DATA_W-1:0] mem_writedata,
  output logic [MEM_DATA_W-1:0] mem_readdata,
  output logic                  mem_busywait,
  output logic                  protocol_error
);
  state_t state;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [MEM_DATA_W-1:0] wdata_q;
  logic write_q;
  logic cnt_zero;
  logic [CNT_W-1:0] cnt_value;
  logic [MEM_DATA_W-1:0] mem_array [DEPTH];
  logic accept, complete;
  assign accept = state == IDLE && is_request(mem_read, mem_write);
  assign complete = state == BUSY && cnt_zero;
  assign mem_busywait = reset && (accept || state == BUSY);
  mem_latency_counter u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (accept),
    .load_value (CNT_W'(LATENCY - 2)),
    .decrement  (state == BUSY),
    .count      (cnt_value),
    .zero       (cnt_zero)
  );
  // Array has no reset; an abort forces IDLE so the write enable never fires.
  always_ff @(posedge clock) begin
    if (complete && write_q) mem_array[addr_q] <= wdata_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      mem_readdata <= '0;
      protocol_error <= 1'b0;
    end else begin
      protocol_error <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          addr_q <= mem_address;
          wdata_q <= mem_writedata;
          write_q <= mem_write;
          protocol_error <= mem_read && mem_write;
          state <= BUSY;
        end
        BUSY: if (cnt_zero) begin
          if (!write_q) mem_readdata <= mem_array[addr_q];
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_data_memory.sv
// tb_block_data_memory: randomized scoreboard bench against a behavioural memory model.
module tb_block_data_memory;
  localparam int LAT = 20;
  logic clock = 0, reset = 0, mem_read = 0, mem_write = 0;
  logic [5:0] mem_address = 0;
  logic [31:0] mem_writedata = 0;
  logic [31:0] mem_readdata;
  logic mem_busywait, protocol_error;
  block_data_memory #(.LATENCY(LAT), .DEPTH(64)) dut (
    .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .mem_busywait(mem_busywait), .protocol_error(protocol_error)
  );
  always #5 clock = ~clock;
  typedef struct {logic [31:0] data; bit ne; int run;} exp_t;
  exp_t sb[$];
  logic [31:0] model [int];
  logic [31:0] last_rd = 0;
  int n_checks = 0, n_fail = 0, pe_exp = 0, pe_seen = 0;
  bit prev_busy = 0, prev_pe = 0;
  int run = 0;
  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction
  // Monitor: a falling busywait marks completion; pop and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock); #1;
      if (!reset) begin
        prev_busy = 0; prev_pe = 0; run = 0;
      end else begin
        if (protocol_error) begin
          if (!prev_pe) pe_seen++;
          else check("pe_width", {31'b0, prev_pe}, 32'd0);
        end
        if (mem_busywait) run++;
        else if (prev_busy) begin
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_empty: completion with no pending request");
          end else begin
            e = sb.pop_front();
            check("latency", run, e.run);
            if (e.ne) begin
              n_checks++;
              if (mem_readdata === e.data) begin
                n_fail++;
                $display("FAIL aborted_write: got %h required anything else", mem_readdata);
              end
            end else check("readdata", mem_readdata, e.data);
          end
          run = 0;
        end
        prev_busy = mem_busywait; prev_pe = protocol_error;
      end
    end
  end
  task automatic start(input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] d, input bit chained);
    exp_t e;
    mem_read = rd; mem_write = wr; mem_address = a; mem_writedata = d;
    if (wr) begin
      model[int'(a)] = d;
      e.data = last_rd;
    end else begin
      e.data = model[int'(a)];
      last_rd = e.data;
    end
    if (rd && wr) pe_exp++;
    e.ne = 0;
    e.run = chained ? LAT : LAT - 1;
    sb.push_back(e);
    if (!chained) begin #1; check("busy_rise", {31'b0, mem_busywait}, 32'd1); end
  endtask
  task automatic wait_done(input bit pert);
    int k = 0;
    do begin
      @(negedge clock); k++;
      if (pert && k == 5) begin
        mem_address = mem_address ^ 6'h15;
        mem_writedata = $urandom;
      end
    end while (mem_busywait && k < 300);
    if (mem_busywait) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: busywait still 1 after %0d cycles", k);
    end
  endtask
  task automatic op(input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] d, input bit pert);
    start(rd, wr, a, d, 0);
    wait_done(pert);
    mem_read = 0; mem_write = 0;
    @(negedge clock);
  endtask
  initial begin
    exp_t e;
    mem_read = 1; mem_write = 1;
    repeat (3) @(negedge clock);
    #1;
    check("reset_busywait", {31'b0, mem_busywait}, 32'd0);
    check("reset_readdata", mem_readdata, 32'd0);
    check("reset_pe", {31'b0, protocol_error}, 32'd0);
    @(negedge clock);
    mem_read = 0; mem_write = 0; reset = 1;
    @(negedge clock);
    op(0, 1, 6'h05, 32'hDEADBEEF, 0);
    op(1, 0, 6'h05, 32'h0, 0);
    op(0, 1, 6'h06, 32'h0BADF00D, 0);
    op(0, 1, 6'h0A, 32'h0A0A5555, 0);
    start(0, 1, 6'h2A, 32'h2A2A1234, 0);
    wait_done(0);
    start(1, 0, 6'h0A, 32'h0, 1);
    @(posedge clock); #1;
    check("refill_restart", {31'b0, mem_busywait}, 32'd1);
    wait_done(0);
    mem_read = 0; mem_write = 0;
    @(negedge clock);
    op(1, 1, 6'h10, 32'h12345678, 0);
    op(1, 0, 6'h10, 32'h0, 0);
    op(1, 0, 6'h05, 32'h0, 1);
    mem_write = 1; mem_address = 6'h07; mem_writedata = 32'hCAFEF00D;
    repeat (10) @(negedge clock);
    reset = 0;
    #1;
    check("abort_busywait", {31'b0, mem_busywait}, 32'd0);
    check("abort_readdata", mem_readdata, 32'd0);
    check("abort_pe", {31'b0, protocol_error}, 32'd0);
    last_rd = 0;
    mem_write = 0;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    mem_read = 1; mem_address = 6'h07;
    e.data = 32'hCAFEF00D; e.ne = 1; e.run = LAT - 1;
    sb.push_back(e);
    wait_done(0);
    mem_read = 0;
    @(negedge clock);
    op(1, 0, 6'h05, 32'h0, 0);
    repeat (25) begin
      int r = $urandom_range(0, 9);
      logic [5:0] a = 6'($urandom);
      logic [31:0] d = $urandom;
      bit pert = $urandom_range(0, 3) == 0;
      if (a == 6'h07) a = 6'h08;
      if (r < 8 && r >= 4 && model.exists(int'(a))) op(1, 0, a, d, pert);
      else if (r >= 8) op(1, 1, a, d, pert);
      else op(0, 1, a, d, pert);
    end
    repeat (3) @(negedge clock);
    check("scoreboard_drained", sb.size(), 32'd0);
    check("pe_count", pe_seen, pe_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
